// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared encodings for the counter command sequencer:
//                command opcodes, completion status codes and FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // Completion status codes, valid alongside done
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_SAT   = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // True for opcodes that step the counter
    function automatic logic is_step_op(input logic [1:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_downcounter.sv
`default_nettype none
// ============================================================================
//  Module      : step_downcounter
//  Description : Remaining-steps register for a counter run. Loaded with the
//                step count when a run starts, decremented once per issued
//                step, and flags when the current step is the final one.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                load_i          load load_val_i (has priority over dec_i)
//                load_val_i      step count to load
//                dec_i           consume one step
//                is_last_o       remaining count equals one
//  Revision    : 1.0  initial release
// ============================================================================
module step_downcounter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_last_o
);

    logic [W-1:0] r_rem_q;
    logic [W-1:0] w_rem_d;

    always_comb begin
        w_rem_d = r_rem_q;
        if (load_i) begin
            w_rem_d = load_val_i;
        end else if (dec_i && (r_rem_q != '0)) begin
            // Guarded so a stray decrement can never wrap to all-ones
            w_rem_d = r_rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_q <= '0;
        end else begin
            r_rem_q <= w_rem_d;
        end
    end

    assign is_last_o = (r_rem_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl
//  Description : Command sequencer for a loadable up/down counter. Accepts
//                LOAD / UP-n / DOWN-n / NOP over valid/ready, drives the
//                counter load/enable/direction strobes for the required
//                number of cycles, and reports completion with a one-cycle
//                done pulse plus status (OK / SATURATED / ABORTED).
//  Ports       : clk, rst                 clock / sync active-high reset
//                cmd_valid/cmd_ready      command handshake
//                cmd_op, cmd_arg          opcode and load value / step count
//                abort                    terminate current LOAD or RUN
//                ctr_count                counter's registered value
//                ctr_load, ctr_num2load   counter load strobe and value
//                ctr_enable, ctr_upordown counter step strobe and direction
//                busy, done, status       progress and completion report
//  Revision    : 1.0  initial release
// ============================================================================
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int W        = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic         abort,
    input  logic [W-1:0] ctr_count,
    output logic         ctr_load,
    output logic [W-1:0] ctr_num2load,
    output logic         ctr_enable,
    output logic         ctr_upordown,
    output logic         busy,
    output logic         done,
    output logic [1:0]   status
);

    localparam logic [1:0] C_IDLE = S_IDLE;
    localparam logic [1:0] C_LOAD = S_LOAD;
    localparam logic [1:0] C_RUN  = S_RUN;
    localparam logic [1:0] C_DONE = S_DONE;

    logic [1:0]   r_state_q,  w_state_d;
    logic [W-1:0] r_arg_q,    w_arg_d;
    logic         r_dir_q,    w_dir_d;
    logic [1:0]   r_status_q, w_status_d;

    logic         w_rem_load;
    logic         w_rem_dec;
    logic         w_rem_last;
    logic         w_sat;
    logic         w_accept;

    step_downcounter #(
        .W (W)
    ) u_steps (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_rem_load),
        .load_val_i (cmd_arg),
        .dec_i      (w_rem_dec),
        .is_last_o  (w_rem_last)
    );

    assign w_accept = cmd_valid && (r_state_q == C_IDLE);

    // Counter already at the limit in the run direction: issuing the step
    // would wrap, so the run ends here instead.
    assign w_sat = SATURATE &&
                   (r_dir_q ? (ctr_count == {W{1'b1}}) : (ctr_count == '0));

    always_comb begin
        w_state_d  = r_state_q;
        w_arg_d    = r_arg_q;
        w_dir_d    = r_dir_q;
        w_status_d = r_status_q;
        w_rem_load = 1'b0;
        w_rem_dec  = 1'b0;

        case (r_state_q)
            C_IDLE: begin
                if (w_accept) begin
                    w_arg_d    = cmd_arg;
                    w_status_d = ST_OK;
                    if (cmd_op == OP_LOAD) begin
                        w_state_d = C_LOAD;
                    end else if (is_step_op(cmd_op) && (cmd_arg != '0)) begin
                        w_dir_d    = (cmd_op == OP_UP);
                        w_rem_load = 1'b1;
                        w_state_d  = C_RUN;
                    end else begin
                        // NOP and zero-length runs complete immediately
                        w_state_d = C_DONE;
                    end
                end
            end

            C_LOAD: begin
                w_state_d  = C_DONE;
                w_status_d = abort ? ST_ABORT : ST_OK;
            end

            C_RUN: begin
                // Abort outranks saturation; both suppress this cycle's step
                if (abort) begin
                    w_state_d  = C_DONE;
                    w_status_d = ST_ABORT;
                end else if (w_sat) begin
                    w_state_d  = C_DONE;
                    w_status_d = ST_SAT;
                end else begin
                    w_rem_dec = 1'b1;
                    if (w_rem_last) begin
                        w_state_d  = C_DONE;
                        w_status_d = ST_OK;
                    end
                end
            end

            default: begin
                w_state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= C_IDLE;
            r_arg_q    <= '0;
            r_dir_q    <= 1'b0;
            r_status_q <= ST_OK;
        end else begin
            r_state_q  <= w_state_d;
            r_arg_q    <= w_arg_d;
            r_dir_q    <= w_dir_d;
            r_status_q <= w_status_d;
        end
    end

    // Strobes come from registered state; only abort and the saturation
    // test can suppress them within the cycle.
    assign ctr_load     = (r_state_q == C_LOAD) && !abort;
    assign ctr_num2load = ctr_load ? r_arg_q : '0;
    assign ctr_enable   = (r_state_q == C_RUN) && !abort && !w_sat;
    assign ctr_upordown = ctr_enable && r_dir_q;

    assign cmd_ready = (r_state_q == C_IDLE);
    assign busy      = (r_state_q != C_IDLE);
    assign done      = (r_state_q == C_DONE);
    assign status    = done ? r_status_q : ST_OK;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_ctrl
//  Description : Self-checking bench for counter_ctrl. Two instances (with
//                and without saturation) receive identical commands; each
//                drives its own behavioural 4-bit counter. Outcomes are
//                predicted per command from the arithmetic of the run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_ctrl;
    import counter_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         abort;

    logic [W-1:0] cnt  [2];
    logic         rdy  [2];
    logic         ld   [2];
    logic [W-1:0] n2l  [2];
    logic         en   [2];
    logic         ud   [2];
    logic         bsy  [2];
    logic         dn   [2];
    logic [1:0]   st   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.W(W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ctr_count(cnt[0]),
        .ctr_load(ld[0]), .ctr_num2load(n2l[0]), .ctr_enable(en[0]),
        .ctr_upordown(ud[0]), .busy(bsy[0]), .done(dn[0]), .status(st[0])
    );

    counter_ctrl #(.W(W), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ctr_count(cnt[1]),
        .ctr_load(ld[1]), .ctr_num2load(n2l[1]), .ctr_enable(en[1]),
        .ctr_upordown(ud[1]), .busy(bsy[1]), .done(dn[1]), .status(st[1])
    );

    // Behavioural counter datapath attached to each sequencer
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst)        cnt[i] <= '0;
            else if (ld[i]) cnt[i] <= n2l[i];
            else if (en[i]) cnt[i] <= ud[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outcome of one command: done cycle (relative to accept edge), number
    // of enable and load strobes, final status and final counter value.
    function automatic void predict(input bit sat, input logic [3:0] start,
                                    input logic [1:0] op, input logic [3:0] arg,
                                    input int ab, output int d, output int ne,
                                    output int nl, output logic [1:0] est,
                                    output logic [3:0] fin);
        int n, lim, endc;
        bit up;
        d = 1; ne = 0; nl = 0; est = ST_OK; fin = start;
        if (op == OP_LOAD) begin
            d = 2;
            if (ab == 1) est = ST_ABORT;
            else begin nl = 1; fin = arg; end
        end else if (op != OP_NOP && arg != 0) begin
            n    = int'(arg);
            up   = (op == OP_UP);
            lim  = up ? 15 - int'(start) : int'(start);
            endc = n;
            if (sat && lim < n) begin endc = lim + 1; est = ST_SAT; end
            if (ab != 0 && ab <= endc) begin endc = ab; est = ST_ABORT; end
            ne  = (est == ST_OK) ? n : endc - 1;
            d   = endc + 1;
            fin = up ? 4'(int'(start) + ne) : 4'(int'(start) - ne);
        end
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] arg,
                          input int ab, input bit hold);
        int d[2], ne[2], nl[2], oe[2], ol[2];
        logic [1:0] est[2];
        logic [3:0] fin[2];
        int maxc, mind;
        bit dirv;
        for (int i = 0; i < 2; i++) begin
            predict(i == 0, cnt[i], op, arg, ab, d[i], ne[i], nl[i], est[i], fin[i]);
            oe[i] = 0; ol[i] = 0;
        end
        maxc = (d[0] > d[1]) ? d[0] : d[1];
        mind = (d[0] < d[1]) ? d[0] : d[1];
        dirv = (op == OP_UP);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk); #1;
        for (int c = 1; c <= maxc; c++) begin
            abort     = (ab == c);
            cmd_valid = hold && (c <= mind);
            if (hold) begin cmd_op = OP_LOAD; cmd_arg = 4'($urandom); end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (en[i]) oe[i]++;
                if (ld[i]) ol[i]++;
                check($sformatf("excl[%0d]", i), ld[i] & en[i], 0);
                check($sformatf("num2load[%0d]", i), n2l[i], ld[i] ? arg : 4'd0);
                check($sformatf("upordown[%0d]", i), ud[i], en[i] ? dirv : 1'b0);
                check($sformatf("busy[%0d]", i), bsy[i], c <= d[i]);
                check($sformatf("ready[%0d]", i), rdy[i], c > d[i]);
                check($sformatf("done[%0d]", i), dn[i], c == d[i]);
                if (dn[i]) check($sformatf("status[%0d]", i), st[i], est[i]);
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("enables[%0d]", i), oe[i], ne[i]);
            check($sformatf("loads[%0d]", i), ol[i], nl[i]);
            check($sformatf("count[%0d]", i), cnt[i], fin[i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ready[%0d]", tag, i), rdy[i], 1);
            check($sformatf("%s_busy[%0d]", tag, i), bsy[i], 0);
            check($sformatf("%s_load[%0d]", tag, i), ld[i], 0);
            check($sformatf("%s_enable[%0d]", tag, i), en[i], 0);
            check($sformatf("%s_done[%0d]", tag, i), dn[i], 0);
            check($sformatf("%s_status[%0d]", tag, i), st[i], 0);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        do_cmd(OP_LOAD, 4'd9, 0, 1'b0);
        do_cmd(OP_LOAD, 4'd3, 0, 1'b0);
        do_cmd(OP_UP,   4'd5, 0, 1'b0);
        do_cmd(OP_LOAD, 4'd13, 0, 1'b0);
        do_cmd(OP_UP,   4'd6, 0, 1'b0);
        do_cmd(OP_DOWN, 4'd0, 0, 1'b0);
        do_cmd(OP_NOP,  4'd7, 0, 1'b0);
        do_cmd(OP_LOAD, 4'd12, 0, 1'b0);
        do_cmd(OP_DOWN, 4'd10, 4, 1'b1);
        do_cmd(OP_LOAD, 4'd0, 0, 1'b0);
        do_cmd(OP_DOWN, 4'd3, 0, 1'b1);
        do_cmd(OP_LOAD, 4'd5, 1, 1'b0);

        // Reset in the middle of a run: no done, outputs back to idle
        do_cmd(OP_LOAD, 4'd2, 0, 1'b0);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check($sformatf("postrst_done[%0d]", i), dn[i], 0);
        end

        // Randomized commands
        for (int k = 0; k < 60; k++) begin
            logic [1:0] op;
            logic [3:0] arg;
            int ab;
            op  = 2'($urandom_range(0, 3));
            arg = 4'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            do_cmd(op, arg, ab, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
